// File: rtl/pipe_control.sv
// pipe_control
// Control unit for a classic five-stage pipeline. It decodes the instruction
// sitting in ID into a control bundle, then carries that bundle through the
// ID/EX, EX/MEM and MEM/WB registers. It also generates the front-end controls
// (PC write, IF/ID write, IF/ID flush) for these events:
//   - load-use hazards
//   - taken branches
//   - jumps
//   - external freezes
//
// Ports
//   clk, rst_n              clock, asynchronous active-low reset
//   opcode, funct           instruction fields of the instruction in ID
//   id_rs, id_rt, id_rd     register fields of the instruction in ID
//   branch_taken            branch resolved taken in EX this cycle
//   stall_ext               external freeze request (memory wait)
//   id_jump                 00 none, 01 j, 10 jal, 11 jr (combinational)
//   id_illegal              unrecognised opcode/funct in ID
//   pc_write, ifid_write,
//   ifid_flush              front-end pipeline control
//   ex_reg_dst_sel, ex_alu_src, ex_alu_op, ex_branch   EX-stage controls
//   mem_read, mem_write     MEM-stage access type (00 none, 01 word, 10 byte, 11 half)
//   wb_reg_write, wb_memto_reg, wb_dest                WB-stage controls

module pipe_control #(
   parameter int REG_ADDR_W = 5,
   parameter int ALUOP_W    = 3,
   parameter int HAZARD_EN  = 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [5:0]            opcode,
   input  logic [5:0]            funct,
   input  logic [REG_ADDR_W-1:0] id_rs,
   input  logic [REG_ADDR_W-1:0] id_rt,
   input  logic [REG_ADDR_W-1:0] id_rd,
   input  logic                  branch_taken,
   input  logic                  stall_ext,
   output logic [1:0]            id_jump,
   output logic                  id_illegal,
   output logic                  pc_write,
   output logic                  ifid_write,
   output logic                  ifid_flush,
   output logic                  ex_reg_dst_sel,
   output logic                  ex_alu_src,
   output logic [ALUOP_W-1:0]    ex_alu_op,
   output logic [1:0]            ex_branch,
   output logic [1:0]            mem_read,
   output logic [1:0]            mem_write,
   output logic                  wb_reg_write,
   output logic                  wb_memto_reg,
   output logic [REG_ADDR_W-1:0] wb_dest
);

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_LB    = 6'b100000;
   localparam logic [5:0] OP_LH    = 6'b100001;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_SB    = 6'b101000;
   localparam logic [5:0] OP_SH    = 6'b101001;
   localparam logic [5:0] OP_LUI   = 6'b001111;
   localparam logic [5:0] OP_ANDI  = 6'b001100;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_JAL   = 6'b000011;
   localparam logic [5:0] FN_JR    = 6'b001000;

   localparam logic [ALUOP_W-1:0] ALU_ADD   = ALUOP_W'(3'd0);
   localparam logic [ALUOP_W-1:0] ALU_RTYPE = ALUOP_W'(3'd1);
   localparam logic [ALUOP_W-1:0] ALU_AND   = ALUOP_W'(3'd2);
   localparam logic [ALUOP_W-1:0] ALU_OR    = ALUOP_W'(3'd3);
   localparam logic [ALUOP_W-1:0] ALU_LUI   = ALUOP_W'(3'd4);
   localparam logic [ALUOP_W-1:0] ALU_SUB   = ALUOP_W'(3'd5);

   // Full bundle as held in ID/EX; later stages keep only what they still need.
   typedef struct packed {
      logic                  reg_dst_sel;
      logic                  alu_src;
      logic [ALUOP_W-1:0]    alu_op;
      logic [1:0]            branch;
      logic [1:0]            mem_read;
      logic [1:0]            mem_write;
      logic                  reg_write;
      logic                  memto_reg;
      logic [REG_ADDR_W-1:0] dest;
   } idex_t;

   typedef struct packed {
      logic [1:0]            mem_read;
      logic [1:0]            mem_write;
      logic                  reg_write;
      logic                  memto_reg;
      logic [REG_ADDR_W-1:0] dest;
   } exmem_t;

   typedef struct packed {
      logic                  reg_write;
      logic                  memto_reg;
      logic [REG_ADDR_W-1:0] dest;
   } memwb_t;

   idex_t  dec;
   idex_t  idex;
   exmem_t exmem;
   memwb_t memwb;
   logic   load_use;
   logic   idex_bubble;

   // Instruction decode for the instruction in ID.
   // Anything not recognised decodes to the all-zero bundle and raises
   // id_illegal, so it flows down the pipe as a harmless bubble. jr and j carry
   // an all-zero bundle too: their only effect is the redirect via id_jump.
   // The accepted R-type functs are the usual shift, arithmetic, logic and
   // set-less-than group; the ALU resolves the exact operation from funct.
   always_comb begin
      dec        = '0;
      id_jump    = 2'b00;
      id_illegal = 1'b0;
      case (opcode)
         OP_RTYPE: begin
            if (funct == FN_JR) begin
               id_jump = 2'b11;
            end else if (funct inside {6'b000000, 6'b000010, 6'b000011,
                                       6'b100000, 6'b100001, 6'b100010,
                                       6'b100011, 6'b100100, 6'b100101,
                                       6'b100110, 6'b100111, 6'b101010,
                                       6'b101011}) begin
               dec.reg_dst_sel = 1'b1;
               dec.alu_op      = ALU_RTYPE;
               dec.reg_write   = 1'b1;
               dec.dest        = id_rd;
            end else begin
               id_illegal = 1'b1;
            end
         end
         OP_LW, OP_LB, OP_LH: begin
            dec.alu_src   = 1'b1;
            dec.alu_op    = ALU_ADD;
            dec.mem_read  = (opcode == OP_LW) ? 2'b01 :
                            (opcode == OP_LB) ? 2'b10 : 2'b11;
            dec.reg_write = 1'b1;
            dec.memto_reg = 1'b1;
            dec.dest      = id_rt;
         end
         OP_SW, OP_SB, OP_SH: begin
            dec.alu_src   = 1'b1;
            dec.alu_op    = ALU_ADD;
            dec.mem_write = (opcode == OP_SW) ? 2'b01 :
                            (opcode == OP_SB) ? 2'b10 : 2'b11;
         end
         OP_LUI, OP_ANDI, OP_ORI: begin
            dec.alu_src   = 1'b1;
            dec.alu_op    = (opcode == OP_LUI)  ? ALU_LUI :
                            (opcode == OP_ANDI) ? ALU_AND : ALU_OR;
            dec.reg_write = 1'b1;
            dec.dest      = id_rt;
         end
         OP_BEQ, OP_BNE: begin
            dec.alu_op = ALU_SUB;
            dec.branch = (opcode == OP_BEQ) ? 2'b01 : 2'b10;
         end
         OP_J: begin
            id_jump = 2'b01;
         end
         OP_JAL: begin
            // Link register is the top register index (r31 at the default width).
            id_jump       = 2'b10;
            dec.reg_write = 1'b1;
            dec.dest      = '1;
         end
         default: begin
            id_illegal = 1'b1;
         end
      endcase
   end

   // Hazard detection and front-end control.
   // The priority chain is freeze, then taken branch, then load-use, then jump
   // flush. A load-use stall inserts one bubble. That bubble clears ID/EX, so
   // the hazard resolves by itself on the following cycle.
   always_comb begin
      load_use = (HAZARD_EN != 0) && (idex.mem_read != 2'b00) &&
                 (idex.dest != '0) &&
                 ((idex.dest == id_rs) || (idex.dest == id_rt));
      pc_write    = 1'b1;
      ifid_write  = 1'b1;
      ifid_flush  = 1'b0;
      idex_bubble = 1'b0;
      if (stall_ext) begin
         pc_write   = 1'b0;
         ifid_write = 1'b0;
      end else if (branch_taken) begin
         ifid_flush  = 1'b1;
         idex_bubble = 1'b1;
      end else if (load_use) begin
         pc_write    = 1'b0;
         ifid_write  = 1'b0;
         idex_bubble = 1'b1;
      end else if (id_jump != 2'b00) begin
         ifid_flush = 1'b1;
      end
   end

   // Stage registers.
   // Reset empties the whole pipe at once. A freeze holds every stage.
   // Otherwise each stage advances, and ID/EX takes either the decode or a bubble.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idex  <= '0;
         exmem <= '0;
         memwb <= '0;
      end else if (!stall_ext) begin
         idex            <= idex_bubble ? '0 : dec;
         exmem.mem_read  <= idex.mem_read;
         exmem.mem_write <= idex.mem_write;
         exmem.reg_write <= idex.reg_write;
         exmem.memto_reg <= idex.memto_reg;
         exmem.dest      <= idex.dest;
         memwb.reg_write <= exmem.reg_write;
         memwb.memto_reg <= exmem.memto_reg;
         memwb.dest      <= exmem.dest;
      end
   end

   assign ex_reg_dst_sel = idex.reg_dst_sel;
   assign ex_alu_src     = idex.alu_src;
   assign ex_alu_op      = idex.alu_op;
   assign ex_branch      = idex.branch;
   assign mem_read       = exmem.mem_read;
   assign mem_write      = exmem.mem_write;
   assign wb_reg_write   = memwb.reg_write;
   assign wb_memto_reg   = memwb.memto_reg;
   assign wb_dest        = memwb.dest;

endmodule

// File: doc/pipe_control.md
PIPE_CONTROL -- requirements
Module: pipe_control

Interface
REQ-001 Parameter REG_ADDR_W, default 5, register-address width.
REQ-002 Parameter ALUOP_W, default 3, width of ALU operation code (minimum 3).
REQ-003 Parameter HAZARD_EN, default 1; when 0, load-use detection is disabled.
REQ-004 clk  in  1  single clock, all state updates on the rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 opcode, funct  in  6 each  instruction fields of the instruction in ID.
REQ-007 id_rs, id_rt, id_rd  in  REG_ADDR_W  register fields of the instruction in ID.
REQ-008 branch_taken  in  1  branch resolved taken in EX this cycle.
REQ-009 stall_ext  in  1  external freeze request (memory wait).
REQ-010 id_jump  out  2  00 none, 01 j, 10 jal, 11 jr; combinational from ID.
REQ-011 id_illegal  out  1  unrecognised opcode/funct in ID.
REQ-012 pc_write, ifid_write, ifid_flush  out  1 each  front-end pipeline control.
REQ-013 ex_reg_dst_sel, ex_alu_src  out  1 each; ex_alu_op  out  ALUOP_W; ex_branch  out  2 (01 beq, 10 bne).
REQ-014 mem_read, mem_write  out  2 each  00 none, 01 word, 10 byte, 11 half.
REQ-015 wb_reg_write, wb_memto_reg  out  1 each; wb_dest  out  REG_ADDR_W.

Function
REQ-016 Decode shall be combinational in ID: R-type 000000; lw 100011, lb 100000, lh 100001; sw 101011, sb 101000, sh 101001; lui 001111, andi 001100, ori 001101; beq 000100, bne 000101; j 000010, jal 000011; jr shall be R-type with funct 001000.
REQ-017 ALU op codes: 000 add (loads/stores), 001 R-type by funct, 010 and, 011 or, 100 lui, 101 sub (branches).
REQ-018 Destination in ID: rd for R-type, rt for loads/lui/andi/ori, 31 for jal; jal shall assert reg_write; jr, j, stores and branches shall not.
REQ-019 Control bundle shall pass through three registers ID/EX, EX/MEM, MEM/WB, one cycle each: ex_* valid 1 cycle, mem_* 2 cycles, wb_* 3 cycles after the instruction is in ID.
REQ-020 Bubble = all-zero bundle; illegal opcode/funct shall decode to bubble and assert id_illegal.
REQ-021 Load-use hazard: HAZARD_EN=1, ID/EX mem_read!=00, ID/EX dest!=0, and dest equals id_rs or id_rt.
REQ-022 On hazard: pc_write=0, ifid_write=0, ID/EX loads bubble, EX/MEM and MEM/WB advance; lasts exactly one cycle per load.
REQ-023 On branch_taken: ifid_flush=1, ID/EX loads bubble; overrides load-use hazard (pc_write=1).
REQ-024 On id_jump!=00 with no branch_taken: ifid_flush=1, ID/EX loads the jump bundle normally.
REQ-025 stall_ext=1 overrides all: pc_write=0, ifid_write=0, ifid_flush=0, all three stage registers hold.
REQ-026 Priority: stall_ext > branch_taken > load-use hazard > jump flush > normal advance.
REQ-027 Otherwise pc_write=1, ifid_write=1, ifid_flush=0.

Reset
REQ-028 rst_n low shall immediately clear all stage registers to bubble: all ex_*, mem_*, wb_* outputs 0.
REQ-029 Reset mid-operation shall discard in-flight instructions; first rising edge after rst_n high loads the ID decode.

Verification
REQ-030 lw rt=8 then add rs=8 in ID -> one cycle pc_write=0, ifid_write=0, bubble in EX; add reaches wb 1 cycle late.
REQ-031 add rd=3 in ID, no hazards -> ex_alu_op=001 next cycle, wb_reg_write=1, wb_dest=3 three cycles later.
REQ-032 jal in ID -> id_jump=10, ifid_flush=1 same cycle, wb_dest=31, wb_reg_write=1 three cycles later.
REQ-033 branch_taken=1 with load-use hazard same cycle -> ifid_flush=1, pc_write=1, ID/EX bubble.
REQ-034 stall_ext=1 for 3 cycles during sb -> mem_write=10 held 3 cycles, pc_write=0 throughout.
REQ-035 opcode 111111 -> id_illegal=1, bubble propagates, no reg or memory write; rst_n pulse mid-stream -> all outputs 0 at once.
